// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the multi-cycle MIPS datapath and its Moore control unit.
// The control unit takes the master modport; the datapath, or a bench, takes the slave.
interface mc_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Op;
    logic [5:0]       Function;
    logic             Zero;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             PCSource;
    logic             PCSel;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegWrite;
    logic             RegDst;
    logic [3:0]       ALUCtrl;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  Op, Function, Zero,
        output IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, PCSel,
               ALUSrcA, ALUSrcB, RegWrite, RegDst, ALUCtrl,
               instr_done, illegal, retired
    );

    modport slave (
        output Op, Function, Zero,
        input  IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, PCSel,
               ALUSrcA, ALUSrcB, RegWrite, RegDst, ALUCtrl,
               instr_done, illegal, retired
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control unit for the multi-cycle MIPS datapath, with a sticky illegal flag and a retire counter.
// Define MC_CTRL_ADDI_EN to build the addi (Op 0x08) states; otherwise addi halts as illegal.
module mc_control_fsm #(
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              reset,
    mc_control_fsm_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'h08;
`endif
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPE_EX, RTYPE_WB, BEQ_EX,
`ifdef MC_CTRL_ADDI_EN
        ADDI_EX, ADDI_WB,
`endif
        HALT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             rtype_ok;
    logic [3:0]       rtype_ctrl;
    logic             illegal_q;
    logic [CNT_W-1:0] count;

    always_comb begin
        rtype_ok   = 1'b1;
        rtype_ctrl = ALU_ADD;
        case (bus.Function)
            6'h20:   rtype_ctrl = ALU_ADD;
            6'h22:   rtype_ctrl = ALU_SUB;
            6'h24:   rtype_ctrl = ALU_AND;
            6'h25:   rtype_ctrl = ALU_OR;
            6'h2A:   rtype_ctrl = ALU_SLT;
            6'h27:   rtype_ctrl = ALU_NOR;
            default: rtype_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPE_EX;
                    OP_BEQ:       next_state = BEQ_EX;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      next_state = ADDI_EX;
`endif
                    default:      next_state = HALT;
                endcase
            end
            MEMADR:   next_state = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWR:    next_state = FETCH;
            RTYPE_EX: next_state = rtype_ok ? RTYPE_WB : HALT;
            RTYPE_WB: next_state = FETCH;
            BEQ_EX:   next_state = FETCH;
`ifdef MC_CTRL_ADDI_EN
            ADDI_EX:  next_state = ADDI_WB;
            ADDI_WB:  next_state = FETCH;
`endif
            HALT:     next_state = HALT;
            default:  next_state = HALT;
        endcase
    end

    // Reset gates every strobe so a half-finished instruction can never write anything.
    always_comb begin
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCSource   = 1'b0;
        bus.PCSel      = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.RegWrite   = 1'b0;
        bus.RegDst     = 1'b0;
        bus.ALUCtrl    = 4'b0000;
        bus.instr_done = 1'b0;
        if (!reset) begin
            bus.ALUCtrl = ALU_ADD;
            case (state)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.IRWrite = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.PCSel   = 1'b1;
                end
                DECODE: bus.ALUSrcB = 2'b10;
                MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = 1'b1;
                end
                MEMWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.MemtoReg   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                MEMWR: begin
                    bus.IorD       = 1'b1;
                    bus.MemWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                RTYPE_EX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUCtrl = rtype_ctrl;
                end
                RTYPE_WB: begin
                    bus.RegWrite   = 1'b1;
                    bus.RegDst     = 1'b1;
                    bus.instr_done = 1'b1;
                end
                BEQ_EX: begin
                    bus.ALUSrcA    = 1'b1;
                    bus.ALUCtrl    = ALU_SUB;
                    bus.PCSource   = 1'b1;
                    bus.PCSel      = bus.Zero;
                    bus.instr_done = 1'b1;
                end
`ifdef MC_CTRL_ADDI_EN
                ADDI_EX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                ADDI_WB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
`endif
                default: bus.ALUCtrl = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
            count     <= '0;
        end else begin
            if (next_state == HALT) begin
                illegal_q <= 1'b1;
            end
            if (bus.instr_done) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign bus.illegal = illegal_q;
    assign bus.retired = count;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle against hand-computed strobes.
// A 3-bit retire counter is used so the wrap boundary is reachable; honours MC_CTRL_ADDI_EN.
module tb_mc_control_fsm;
    localparam int TB_CNT_W = 3;

    // Control vector layout, msb first:
    // IorD MemRead MemWrite MemtoReg IRWrite PCSource PCSel ALUSrcA | ALUSrcB[1:0] | RegWrite RegDst | ALUCtrl[3:0]
    localparam logic [15:0] E_ZERO     = 16'h0000;
    localparam logic [15:0] E_FETCH    = {8'b0100_1010, 2'b01, 2'b00, 4'b0010};
    localparam logic [15:0] E_DECODE   = {8'b0000_0000, 2'b10, 2'b00, 4'b0010};
    localparam logic [15:0] E_MEMADR   = {8'b0000_0001, 2'b10, 2'b00, 4'b0010};
    localparam logic [15:0] E_MEMRD    = {8'b1100_0000, 2'b00, 2'b00, 4'b0010};
    localparam logic [15:0] E_MEMWB    = {8'b0001_0000, 2'b00, 2'b10, 4'b0010};
    localparam logic [15:0] E_MEMWR    = {8'b1010_0000, 2'b00, 2'b00, 4'b0010};
    localparam logic [15:0] E_RTYPE_WB = {8'b0000_0000, 2'b00, 2'b11, 4'b0010};
`ifdef MC_CTRL_ADDI_EN
    localparam logic [15:0] E_ADDI_EX  = {8'b0000_0001, 2'b10, 2'b00, 4'b0010};
    localparam logic [15:0] E_ADDI_WB  = {8'b0000_0000, 2'b00, 2'b10, 4'b0010};
`endif

    logic                clk = 1'b0;
    logic                reset;
    int                  checks = 0;
    int                  errors = 0;
    logic [TB_CNT_W-1:0] exp_ret;
    logic [15:0]         ctl_vec;

    mc_control_fsm_if #(.CNT_W(TB_CNT_W)) bus ();

    mc_control_fsm #(.CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign ctl_vec = {bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.IRWrite,
                      bus.PCSource, bus.PCSel, bus.ALUSrcA, bus.ALUSrcB,
                      bus.RegWrite, bus.RegDst, bus.ALUCtrl};

    function automatic logic [15:0] e_rtype_ex(input logic [3:0] alu);
        return {8'b0000_0001, 2'b00, 2'b00, alu};
    endfunction

    function automatic logic [15:0] e_beq(input logic z);
        return {5'b00000, 1'b1, z, 1'b1, 2'b00, 2'b00, 4'b0110};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge: checks the current state's outputs, then advances one cycle.
    task automatic check_cycle(input string tag, input logic [15:0] exp_ctl, input logic exp_done);
        #1;
        check_output({tag, "_ctl"}, 32'(ctl_vec), 32'(exp_ctl));
        check_output({tag, "_done"}, 32'(bus.instr_done), 32'(exp_done));
        @(negedge clk);
    endtask

    task automatic check_status(input string tag, input logic exp_illegal);
        #1;
        check_output({tag, "_retired"}, 32'(bus.retired), 32'(exp_ret));
        check_output({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_illegal));
    endtask

    initial begin
        reset        = 1'b1;
        bus.Op       = 6'h00;
        bus.Function = 6'h00;
        bus.Zero     = 1'b0;
        exp_ret      = '0;

        repeat (2) begin
            @(negedge clk);
            #1;
            check_output("reset_ctl", 32'(ctl_vec), 32'(E_ZERO));
            check_output("reset_done", 32'(bus.instr_done), 32'h0);
        end
        check_status("reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;

        bus.Op = 6'h23;
        check_cycle("lw_fetch", E_FETCH, 1'b0);
        check_cycle("lw_decode", E_DECODE, 1'b0);
        check_cycle("lw_memadr", E_MEMADR, 1'b0);
        check_cycle("lw_memrd", E_MEMRD, 1'b0);
        check_cycle("lw_memwb", E_MEMWB, 1'b1);
        exp_ret++;
        check_status("lw", 1'b0);

        bus.Op = 6'h2B;
        check_cycle("sw_fetch", E_FETCH, 1'b0);
        check_cycle("sw_decode", E_DECODE, 1'b0);
        check_cycle("sw_memadr", E_MEMADR, 1'b0);
        check_cycle("sw_memwr", E_MEMWR, 1'b1);
        exp_ret++;
        check_status("sw", 1'b0);

        bus.Op = 6'h00;
        bus.Function = 6'h22;
        check_cycle("sub_fetch", E_FETCH, 1'b0);
        check_cycle("sub_decode", E_DECODE, 1'b0);
        check_cycle("sub_ex", e_rtype_ex(4'b0110), 1'b0);
        check_cycle("sub_wb", E_RTYPE_WB, 1'b1);
        exp_ret++;
        check_status("sub", 1'b0);

        bus.Function = 6'h2A;
        check_cycle("slt_fetch", E_FETCH, 1'b0);
        check_cycle("slt_decode", E_DECODE, 1'b0);
        check_cycle("slt_ex", e_rtype_ex(4'b0111), 1'b0);
        check_cycle("slt_wb", E_RTYPE_WB, 1'b1);
        exp_ret++;

        bus.Function = 6'h27;
        check_cycle("nor_fetch", E_FETCH, 1'b0);
        check_cycle("nor_decode", E_DECODE, 1'b0);
        check_cycle("nor_ex", e_rtype_ex(4'b1100), 1'b0);
        check_cycle("nor_wb", E_RTYPE_WB, 1'b1);
        exp_ret++;
        check_status("nor", 1'b0);

        // PCSel in BEQ_EX must follow Zero within the cycle, not a registered copy.
        bus.Op = 6'h04;
        bus.Zero = 1'b1;
        check_cycle("beq1_fetch", E_FETCH, 1'b0);
        check_cycle("beq1_decode", E_DECODE, 1'b0);
        #1;
        check_output("beq1_ex_ctl", 32'(ctl_vec), 32'(e_beq(1'b1)));
        check_output("beq1_ex_done", 32'(bus.instr_done), 32'h1);
        bus.Zero = 1'b0;
        #1;
        check_output("beq_zero_comb", 32'(bus.PCSel), 32'h0);
        @(negedge clk);
        exp_ret++;

        check_cycle("beq0_fetch", E_FETCH, 1'b0);
        check_cycle("beq0_decode", E_DECODE, 1'b0);
        check_cycle("beq0_ex", e_beq(1'b0), 1'b1);
        exp_ret++;
        check_status("beq", 1'b0);

        // Eighth retirement wraps the 3-bit counter back to zero.
        bus.Op = 6'h00;
        bus.Function = 6'h20;
        check_cycle("add_fetch", E_FETCH, 1'b0);
        check_cycle("add_decode", E_DECODE, 1'b0);
        check_cycle("add_ex", e_rtype_ex(4'b0010), 1'b0);
        check_cycle("add_wb", E_RTYPE_WB, 1'b1);
        exp_ret++;
        check_output("wrap_zero", 32'(bus.retired), 32'h0);
        check_status("wrap", 1'b0);

        bus.Op = 6'h04;
        check_cycle("beq2_fetch", E_FETCH, 1'b0);
        check_cycle("beq2_decode", E_DECODE, 1'b0);
        check_cycle("beq2_ex", e_beq(1'b0), 1'b1);
        exp_ret++;
        check_status("beq2", 1'b0);

        // Abort a lw in MEMRD: strobes drop immediately and the next cycle is FETCH.
        bus.Op = 6'h23;
        check_cycle("abort_fetch", E_FETCH, 1'b0);
        check_cycle("abort_decode", E_DECODE, 1'b0);
        check_cycle("abort_memadr", E_MEMADR, 1'b0);
        reset = 1'b1;
        #1;
        check_output("abort_reset_ctl", 32'(ctl_vec), 32'(E_ZERO));
        check_output("abort_reset_done", 32'(bus.instr_done), 32'h0);
        @(negedge clk);
        exp_ret = '0;
        check_status("abort", 1'b0);
        bus.Op = 6'h3F;
        reset = 1'b0;
        check_cycle("abort_refetch", E_FETCH, 1'b0);

        check_cycle("ill_decode", E_DECODE, 1'b0);
        check_status("ill_enter", 1'b1);
        for (int i = 0; i < 10; i++) begin
            check_cycle("halt", E_ZERO, 1'b0);
        end
        check_status("halt_end", 1'b1);

        reset = 1'b1;
        @(negedge clk);
        check_status("halt_reset", 1'b0);
        bus.Op = 6'h08;
        reset = 1'b0;
        check_cycle("addi_fetch", E_FETCH, 1'b0);
        check_cycle("addi_decode", E_DECODE, 1'b0);
`ifdef MC_CTRL_ADDI_EN
        check_cycle("addi_ex", E_ADDI_EX, 1'b0);
        check_cycle("addi_wb", E_ADDI_WB, 1'b1);
        exp_ret++;
        check_status("addi", 1'b0);
        check_cycle("addi_next_fetch", E_FETCH, 1'b0);
`else
        check_cycle("addi_halt", E_ZERO, 1'b0);
        check_status("addi_illegal", 1'b1);
`endif

        // Unknown R-type function code halts after RTYPE_EX.
        reset = 1'b1;
        @(negedge clk);
        exp_ret = '0;
        bus.Op = 6'h00;
        bus.Function = 6'h3F;
        reset = 1'b0;
        check_cycle("badfn_fetch", E_FETCH, 1'b0);
        check_cycle("badfn_decode", E_DECODE, 1'b0);
        @(negedge clk);
        check_cycle("badfn_halt", E_ZERO, 1'b0);
        check_status("badfn", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
